// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result-select pipeline: default sizes,
// opcode constants, the result-entry layout and the output-buffer occupancy.
package alu_pkg;

  localparam int unsigned N_DEF       = 16;
  localparam int unsigned NUM_OPS_DEF = 11;
  localparam int unsigned OPW_DEF     = 4;

  // Default opcode assignments for the functional-unit result channels.
  localparam logic [OPW_DEF-1:0] OP_ADD   = 4'd0;
  localparam logic [OPW_DEF-1:0] OP_SUB   = 4'd1;
  localparam logic [OPW_DEF-1:0] OP_MULT  = 4'd2;
  localparam logic [OPW_DEF-1:0] OP_OR    = 4'd3;
  localparam logic [OPW_DEF-1:0] OP_AND   = 4'd4;
  localparam logic [OPW_DEF-1:0] OP_XOR   = 4'd5;
  localparam logic [OPW_DEF-1:0] OP_RS    = 4'd6;
  localparam logic [OPW_DEF-1:0] OP_LS    = 4'd7;
  localparam logic [OPW_DEF-1:0] OP_RR    = 4'd8;
  localparam logic [OPW_DEF-1:0] OP_HOLD  = 4'd9;
  localparam logic [OPW_DEF-1:0] OP_INSTA = 4'd10;

  // Status flags travelling with every buffered result.
  typedef struct packed {
    logic zero;
    logic neg;
    logic err;
  } res_flags_t;

  // Result entry at the default datapath width.
  typedef struct packed {
    logic [N_DEF-1:0] data;
    logic             zero;
    logic             neg;
    logic             err;
  } res_entry_t;

  // Occupancy of the 2-entry output buffer.
  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_occ_t;

endpackage

// File: rtl/alu_result_fifo2.sv
// Generic 2-entry valid/ready buffer. in_ready_o is registered from the
// next occupancy so it never depends combinationally on out_ready_i.
module alu_result_fifo2
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);

  fifo_occ_t      occ_q, occ_d;
  logic [W-1:0]   mem_q [2];
  logic           rd_ptr_q;
  logic           wr_ptr_q;
  logic           ready_q;
  logic           push;
  logic           pop;

  assign push        = in_valid_i && ready_q;
  assign pop         = (occ_q != FIFO_EMPTY) && out_ready_i;
  assign in_ready_o  = ready_q;
  assign out_valid_o = (occ_q != FIFO_EMPTY);
  assign out_data_o  = mem_q[rd_ptr_q];

  // Next occupancy from push/pop; simultaneous push and pop keeps it unchanged.
  always_comb begin
    occ_d = occ_q;
    unique case (occ_q)
      FIFO_EMPTY: if (push) occ_d = FIFO_ONE;
      FIFO_ONE: begin
        if (push && !pop)      occ_d = FIFO_FULL;
        else if (!push && pop) occ_d = FIFO_EMPTY;
      end
      FIFO_FULL:  if (pop) occ_d = FIFO_ONE;
      default:    occ_d = FIFO_EMPTY;
    endcase
  end

  // Occupancy, pointers and the registered ready flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q    <= FIFO_EMPTY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      ready_q <= (occ_d != FIFO_FULL);
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Entry storage; slots not being written keep their previous contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: rtl/alu_result_sel_pipe.sv
// Registered ALU result selector: decodes the opcode, selects one of NUM_OPS
// result channels (or the last committed result on HOLD_OP), computes flags
// and hands entries to a 2-entry valid/ready output buffer.
// Optional feature macro: ALU_RESULT_PARITY_EN adds result_par, the even
// parity over {flag_err, result}, stored per buffered entry.
module alu_result_sel_pipe
  import alu_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned NUM_OPS = NUM_OPS_DEF,
  parameter int unsigned OPW     = OPW_DEF,
  parameter int unsigned HOLD_OP = int'(OP_HOLD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_OPS*N-1:0] ops_in,
  input  logic [OPW-1:0]     opcode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N-1:0]       result,
  output logic               flag_zero,
  output logic               flag_neg,
  output logic               flag_err,
  output logic               out_valid,
`ifdef ALU_RESULT_PARITY_EN
  output logic               result_par,
`endif
  input  logic               out_ready
);

  typedef struct packed {
`ifdef ALU_RESULT_PARITY_EN
    logic       par;
`endif
    logic [N-1:0] data;
    res_flags_t   flags;
  } entry_t;

  logic [N-1:0] last_q;
  logic [N-1:0] sel_data;
  logic         sel_err;
  logic         load_last;
  logic         accept;
  entry_t       in_entry;
  entry_t       head;

  assign accept = in_valid && in_ready;

  // Opcode decode; HOLD_OP is checked first so it wins even inside 0..NUM_OPS-1.
  always_comb begin
    sel_data  = '0;
    sel_err   = 1'b0;
    load_last = 1'b0;
    if (32'(opcode) == HOLD_OP) begin
      sel_data = last_q;
    end else if (32'(opcode) < NUM_OPS) begin
      for (int unsigned k = 0; k < NUM_OPS; k++) begin
        if (32'(opcode) == k) sel_data = ops_in[k*N +: N];
      end
      load_last = 1'b1;
    end else begin
      sel_err = 1'b1;
    end
  end

  // Flags are derived from the selected data before it enters the buffer.
  always_comb begin
    in_entry            = '0;
    in_entry.data       = sel_data;
    in_entry.flags.zero = (sel_data == '0);
    in_entry.flags.neg  = sel_data[N-1];
    in_entry.flags.err  = sel_err;
`ifdef ALU_RESULT_PARITY_EN
    in_entry.par        = ^{sel_err, sel_data};
`endif
  end

  // Last committed legal result, re-issued by HOLD_OP in place of a latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= '0;
    end else if (accept && load_last) begin
      last_q <= sel_data;
    end
  end

  alu_result_fifo2 #(
    .W ($bits(entry_t))
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_entry),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (head),
    .out_ready_i (out_ready)
  );

  assign result    = head.data;
  assign flag_zero = head.flags.zero;
  assign flag_neg  = head.flags.neg;
  assign flag_err  = head.flags.err;
`ifdef ALU_RESULT_PARITY_EN
  assign result_par = head.par;
`endif

endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Self-checking bench for alu_result_sel_pipe: table-driven vectors plus
// hand-written stall/reset sequences, with an expected-result scoreboard.
module tb_alu_result_sel_pipe;

  localparam int unsigned N  = 16;
  localparam int unsigned NO = 11;

  typedef struct {
    logic [15:0] data;
    logic        zero;
    logic        neg;
    logic        err;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    int          ch;
    logic [15:0] val;
    logic [15:0] ed;
    logic        ez;
    logic        en;
    logic        ee;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NO*N-1:0]   ops_in;
  logic [3:0]        opcode;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       result;
  logic              flag_zero, flag_neg, flag_err;
  logic              out_valid;
  logic              out_ready;
`ifdef ALU_RESULT_PARITY_EN
  logic              result_par;
`endif

  int   total  = 0;
  int   passed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_result_sel_pipe #(
    .N       (16),
    .NUM_OPS (11),
    .OPW     (4),
    .HOLD_OP (9)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ops_in    (ops_in),
    .opcode    (opcode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .flag_zero (flag_zero),
    .flag_neg  (flag_neg),
    .flag_err  (flag_err),
    .out_valid (out_valid),
`ifdef ALU_RESULT_PARITY_EN
    .result_par(result_par),
`endif
    .out_ready (out_ready)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
  endtask

  // Output monitor: pops the scoreboard on each handshake, checks stall stability.
  logic        stall_prev = 1'b0;
  logic [18:0] prev_out;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (stall_prev) chk("stall_stable", 32'({result, flag_zero, flag_neg, flag_err}), 32'(prev_out));
      if (out_ready) begin
        stall_prev = 1'b0;
        if (sb.size() == 0) begin
          chk("spurious_output", 32'(out_valid), 32'(1'b0));
        end else begin
          e = sb.pop_front();
          chk("result", 32'(result), 32'(e.data));
          chk("flag_zero", 32'(flag_zero), 32'(e.zero));
          chk("flag_neg", 32'(flag_neg), 32'(e.neg));
          chk("flag_err", 32'(flag_err), 32'(e.err));
`ifdef ALU_RESULT_PARITY_EN
          chk("result_par", 32'(result_par), 32'(^{e.err, e.data}));
`endif
        end
      end else begin
        stall_prev = 1'b1;
        prev_out   = {result, flag_zero, flag_neg, flag_err};
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Present one op (called just after a rising edge); returns just after its accept edge.
  task automatic send(input logic [3:0] op, input int ch, input logic [15:0] val,
                      input logic [15:0] ed, input logic ez, input logic en, input logic ee);
    exp_t e;
    int   waited = 0;
    opcode = op;
    if (ch >= 0 && ch < int'(NO)) ops_in[ch*16 +: 16] = val;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 40) begin
        total++;
        $display("FAIL send_timeout: in_ready=%0b required=1", in_ready);
        in_valid = 1'b0;
        return;
      end
    end
    e.data = ed; e.zero = ez; e.neg = en; e.err = ee;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[11];
    logic [15:0] svals[8];
    logic [15:0] v;

    tbl[0]  = '{4'd0,  0, 16'h8001, 16'h8001, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{4'd9,  0, 16'h1234, 16'h8001, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{4'd15, -1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{4'd9,  -1, 16'h0000, 16'h8001, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{4'd11, -1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{4'd10, 10, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{4'd9,  -1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{4'd8,  8, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{4'd12, -1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{4'd9,  -1, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{4'd7,  7, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b0};
    svals = '{16'h0011, 16'h8000, 16'h0000, 16'h7FFF, 16'hFFFE, 16'h0123, 16'h4000, 16'h00FF};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; opcode = '0;
    for (int k = 0; k < int'(NO); k++) ops_in[k*16 +: 16] = 16'(16'h0A00 + k);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'(1'b0));
    chk("rst_in_ready", 32'(in_ready), 32'(1'b0));
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_flags", 32'({flag_zero, flag_neg, flag_err}), 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("in_ready_after_release", 32'(in_ready), 32'(1'b1));

    // First transaction and its one-cycle latency
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'd2, 2, 16'h0042, 16'h0042, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("latency_out_valid", 32'(out_valid), 32'(1'b1));
    @(posedge clk); #1;

    // Table vectors, back to back
    for (int i = 0; i < 11; i++) begin
      send(tbl[i].op, tbl[i].ch, tbl[i].val, tbl[i].ed, tbl[i].ez, tbl[i].en, tbl[i].ee);
    end
    idle();
    drain();

    // Full buffer with out_ready low; third op waits for space
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'd1, 1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    send(4'd3, 3, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'(1'b0));
    chk("full_out_valid", 32'(out_valid), 32'(1'b1));
    chk("full_head", 32'(result), 32'h0001);
    @(posedge clk); #1;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    send(4'd5, 5, 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0);
    idle();
    drain();

    // Streaming with out_ready toggling every cycle
    @(posedge clk); #1;
    fork
      begin
        for (int t = 0; t < 24; t++) begin
          @(posedge clk);
          #1 out_ready = ~out_ready;
        end
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 8; i++) begin
      v = svals[i];
      send(4'(i), i, v, v, (v == 16'h0), v[15], 1'b0);
    end
    idle();
    drain();
    repeat (30) @(posedge clk);
    #1;

    // Reset while the buffer holds two entries
    out_ready = 1'b0;
    send(4'd4, 4, 16'h0777, 16'h0777, 1'b0, 1'b0, 1'b0);
    send(4'd6, 6, 16'h0888, 16'h0888, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("pre_rst_in_ready", 32'(in_ready), 32'(1'b0));
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'(1'b0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(4'd9, -1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    idle();
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
